mmc_spi_arbiter: RTL and testbench

MMC_SPI_ARBITER -- requirements
Module: mmc_spi_arbiter

---
 rtl/mmc_pkg.sv | 21 ++
 rtl/mmc_rr_pick.sv | 22 ++
 rtl/mmc_spi_arbiter.sv | 143 ++++++++++++++
 tb/tb_mmc_spi_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// Shared definitions for the MMC SPI arbiter: FSM encoding, requester indices
// and the default WAIT-state abort limit.
package mmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int REQ_SEQ  = 0;
  localparam int REQ_HOST = 1;

  localparam int TIMEOUT_CYC_DEF = 255;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mmc_rr_pick.sv
// Two-way round-robin choice: on a tie the requester that was not served last
// wins; a lone requester always wins.
module mmc_rr_pick
  import mmc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] pick,
  output logic       pick_idx
);

  always_comb begin
    pick_idx = 1'(REQ_SEQ);
    if (req[REQ_SEQ] && req[REQ_HOST]) begin
      pick_idx = ~last_served;
    end else if (req[REQ_HOST]) begin
      pick_idx = 1'(REQ_HOST);
    end
    pick = (|req) ? idx_to_onehot(pick_idx) : 2'b00;
  end

endmodule

// File: rtl/mmc_spi_arbiter.sv
// Arbitrates the SPI master between the main sequencer and the host register port.
// Define MMC_SPI_TIMEOUT_EN to abort stuck transactions after TIMEOUT_CYC cycles.
module mmc_spi_arbiter
  import mmc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req_rd_wr,
  input  logic [4:0] req_addr0,
  input  logic [4:0] req_addr1,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic [1:0] err,
  output logic [7:0] rd_data,
  output logic       spi_en,
  output logic       spi_rd_wr,
  output logic [4:0] spi_addr,
  output logic [7:0] spi_data,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_data_out,
  output logic       arb_idle
);

  arb_state_t state;
  logic [1:0] gnt_q;
  logic [1:0] ack_q;
  logic [7:0] rd_data_q;
  logic       spi_en_q;
  logic       cmd_rd_wr;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       last_served;
  logic       owner_idx;
  logic [1:0] pick;
  logic       pick_idx;
  logic       tmo_hit;

  mmc_rr_pick u_rr_pick (
    .req         (req),
    .last_served (last_served),
    .pick        (pick),
    .pick_idx    (pick_idx)
  );

`ifdef MMC_SPI_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       err_q;

  // Counter value k means the (k+1)-th cycle spent in ISSUE/WAIT.
  assign tmo_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        // A completion landing on the limit cycle wins over the abort.
        if (tmo_hit && !spi_done) err_q <= gnt_q;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 2'b00;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      rd_data_q   <= '0;
      spi_en_q    <= 1'b0;
      cmd_rd_wr   <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      last_served <= 1'(REQ_HOST);
      owner_idx   <= 1'(REQ_SEQ);
    end else begin
      ack_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt_q     <= pick;
            owner_idx <= pick_idx;
            cmd_rd_wr <= req_rd_wr[pick_idx];
            cmd_addr  <= pick_idx ? req_addr1 : req_addr0;
            cmd_data  <= pick_idx ? req_data1 : req_data0;
            spi_en_q  <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          // spi_done while still in ISSUE counts as busy and done together.
          if (spi_done || tmo_hit) begin
            spi_en_q <= 1'b0;
            ack_q    <= gnt_q;
            state    <= ST_DONE;
            if (spi_done && cmd_rd_wr) rd_data_q <= spi_data_out;
          end else if ((state == ST_ISSUE) && spi_busy) begin
            spi_en_q <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_DONE: begin
          gnt_q       <= '0;
          cmd_rd_wr   <= 1'b0;
          cmd_addr    <= '0;
          cmd_data    <= '0;
          last_served <= owner_idx;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rd_data   = rd_data_q;
  assign spi_en    = spi_en_q;
  assign spi_rd_wr = cmd_rd_wr;
  assign spi_addr  = cmd_addr;
  assign spi_data  = cmd_data;
  assign arb_idle  = (state == ST_IDLE);

endmodule

// File: tb/tb_mmc_spi_arbiter.sv
// Scoreboard bench for mmc_spi_arbiter: directed transactions push expected
// ack/err/rd_data; a negedge monitor pops and compares on every ack or err.
module tb_mmc_spi_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_rd_wr;
  logic [4:0] req_addr0, req_addr1;
  logic [7:0] req_data0, req_data1;
  logic [1:0] gnt, ack, err;
  logic [7:0] rd_data;
  logic       spi_en, spi_rd_wr;
  logic [4:0] spi_addr;
  logic [7:0] spi_data;
  logic       spi_busy, spi_done;
  logic [7:0] spi_data_out;
  logic       arb_idle;

`ifdef MMC_SPI_TIMEOUT_EN
  localparam int T1_DONE = 6;
`else
  localparam int T1_DONE = 10;
`endif

  mmc_spi_arbiter #(.TIMEOUT_CYC(8)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .req          (req),
    .req_rd_wr    (req_rd_wr),
    .req_addr0    (req_addr0),
    .req_addr1    (req_addr1),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .gnt          (gnt),
    .ack          (ack),
    .err          (err),
    .rd_data      (rd_data),
    .spi_en       (spi_en),
    .spi_rd_wr    (spi_rd_wr),
    .spi_addr     (spi_addr),
    .spi_data     (spi_data),
    .spi_busy     (spi_busy),
    .spi_done     (spi_done),
    .spi_data_out (spi_data_out),
    .arb_idle     (arb_idle)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [1:0] ack;
    logic [1:0] err;
    logic [7:0] rd;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [1:0] e, input logic [7:0] r);
    exp_q.push_back(exp_t'{ack: a, err: e, rd: r});
  endtask

  always @(negedge sys_clk) begin
    if (rst !== 1'b1 && (ack !== 2'b00 || err !== 2'b00)) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b err=%b, expected none", ack, err);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ack", 32'(ack), 32'(e.ack));
        chk("sb_err", 32'(err), 32'(e.err));
        chk("sb_rd_data", 32'(rd_data), 32'(e.rd));
      end
    end
  end

  task automatic wait_en(input string nm);
    int n = 0;
    while (spi_en !== 1'b1 && n < 20) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    chk({nm, "_spi_en_seen"}, 32'(spi_en), 32'd1);
  endtask

  // Called on the first ISSUE cycle; busy rises after busy_dly cycles and a
  // one-cycle done follows done_dly cycles after ISSUE entry.
  task automatic finish_spi(input int busy_dly, input int done_dly, input logic [7:0] dout);
    repeat (busy_dly) @(posedge sys_clk);
    #1 spi_busy = 1'b1;
    repeat (done_dly - busy_dly) @(posedge sys_clk);
    #1 spi_done = 1'b1;
    spi_data_out = dout;
    @(posedge sys_clk);
    #1 spi_done = 1'b0;
    spi_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    int n;
    rst = 1'b1; req = '0; req_rd_wr = '0;
    req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_data_out = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_spi_en", 32'(spi_en), 0);
    chk("rst_spi_addr", 32'(spi_addr), 0);
    chk("rst_spi_data", 32'(spi_data), 0);
    chk("rst_spi_rd_wr", 32'(spi_rd_wr), 0);
    chk("rst_arb_idle", 32'(arb_idle), 1);
    rst = 1'b0;
    exp_rd = 8'h00;
    @(posedge sys_clk); #1;

    // Write from the sequencer; the write must not load rd_data.
    req_rd_wr = 2'b00; req_addr0 = 5'h05; req_data0 = 8'hA3; req = 2'b01;
    wait_en("t1");
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_spi_addr", 32'(spi_addr), 32'h05);
    chk("t1_spi_data", 32'(spi_data), 32'hA3);
    chk("t1_spi_rd_wr", 32'(spi_rd_wr), 0);
    chk("t1_arb_idle", 32'(arb_idle), 0);
    req = 2'b00;
    push_exp(2'b01, 2'b00, exp_rd);
    @(posedge sys_clk); #1;
    chk("t1_spi_en_held", 32'(spi_en), 1);
    finish_spi(1, T1_DONE - 1, 8'hEE);
    chk("t1_ack_direct", 32'(ack), 32'h1);
    @(posedge sys_clk); #1;
    chk("t1_idle", 32'(arb_idle), 1);
    chk("t1_gnt_clr", 32'(gnt), 0);
    chk("t1_addr_clr", 32'(spi_addr), 0);
    chk("t1_data_clr", 32'(spi_data), 0);

    // Simultaneous held requests from reset alternate 01, 10, 01.
    rst = 1'b1; @(posedge sys_clk); #1; rst = 1'b0; exp_rd = 8'h00;
    req_rd_wr = 2'b00; req_addr0 = 5'h01; req_data0 = 8'h11;
    req_addr1 = 5'h02; req_data1 = 8'h22; req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_g = (k == 1) ? 2'b10 : 2'b01;
      wait_en("t2");
      chk("t2_gnt_order", 32'(gnt), 32'(exp_g));
      chk("t2_spi_addr", 32'(spi_addr), (exp_g == 2'b01) ? 32'h01 : 32'h02);
      if (k == 2) req = 2'b00;
      push_exp(exp_g, 2'b00, exp_rd);
      finish_spi(0, 3, 8'h00);
      @(posedge sys_clk); #1;
    end
    repeat (2) @(posedge sys_clk); #1;
    chk("t2_idle_after", 32'(arb_idle), 1);

    // Host read captures spi_data_out.
    req_rd_wr = 2'b10; req_addr0 = 5'h03; req_addr1 = 5'h1F; req = 2'b10;
    wait_en("t3");
    chk("t3_gnt", 32'(gnt), 32'h2);
    chk("t3_spi_addr", 32'(spi_addr), 32'h1F);
    chk("t3_spi_rd_wr", 32'(spi_rd_wr), 1);
    req = 2'b00;
    exp_rd = 8'h5C;
    push_exp(2'b10, 2'b00, exp_rd);
    finish_spi(1, 4, 8'h5C);
    @(posedge sys_clk); #1;
    chk("t3_rd_data_hold", 32'(rd_data), 32'h5C);
    chk("t3_rd_wr_clr", 32'(spi_rd_wr), 0);

    // spi_done during ISSUE goes straight to DONE.
    req_rd_wr = 2'b00; req_addr0 = 5'h0A; req = 2'b01;
    wait_en("t4");
    req = 2'b00;
    push_exp(2'b01, 2'b00, exp_rd);
    spi_done = 1'b1; spi_data_out = 8'h77;
    @(posedge sys_clk); #1;
    spi_done = 1'b0;
    chk("t4_direct_done", 32'(ack), 32'h1);
    chk("t4_spi_en_off", 32'(spi_en), 0);
    @(posedge sys_clk); #1;

    // Inputs changing mid-WAIT must not reach the latched command.
    req_rd_wr = 2'b00; req_addr0 = 5'h0C; req_data0 = 8'h3C; req = 2'b01;
    wait_en("t5");
    spi_busy = 1'b1;
    @(posedge sys_clk); #1;
    chk("t5_wait_en_low", 32'(spi_en), 0);
    req_addr0 = 5'h13; req_data0 = 8'hC5; req_rd_wr = 2'b01;
    @(posedge sys_clk); #1;
    chk("t5_addr_stable", 32'(spi_addr), 32'h0C);
    chk("t5_data_stable", 32'(spi_data), 32'h3C);
    chk("t5_rd_wr_stable", 32'(spi_rd_wr), 0);
    req = 2'b00;
    push_exp(2'b01, 2'b00, exp_rd);
    spi_done = 1'b1; spi_data_out = 8'h99;
    @(posedge sys_clk); #1;
    spi_done = 1'b0; spi_busy = 1'b0; req_rd_wr = 2'b00;
    @(posedge sys_clk); #1;

    // Asynchronous reset in WAIT, then in ISSUE.
    req_addr0 = 5'h04; req = 2'b01;
    wait_en("t6");
    spi_busy = 1'b1;
    @(posedge sys_clk); #1;
    req = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("t6_wait_rst_spi_en", 32'(spi_en), 0);
    chk("t6_wait_rst_gnt", 32'(gnt), 0);
    chk("t6_wait_rst_idle", 32'(arb_idle), 1);
    chk("t6_wait_rst_addr", 32'(spi_addr), 0);
    @(posedge sys_clk); #1;
    rst = 1'b0; spi_busy = 1'b0; exp_rd = 8'h00;
    req = 2'b01;
    wait_en("t6b");
    req = 2'b00;
    #2 rst = 1'b1;
    #1;
    chk("t6_issue_rst_spi_en", 32'(spi_en), 0);
    chk("t6_issue_rst_gnt", 32'(gnt), 0);
    chk("t6_issue_rst_idle", 32'(arb_idle), 1);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge sys_clk); #1;

    // Stuck SPI master: abort after 8 cycles, or wait forever.
    req_addr0 = 5'h06; req_rd_wr = 2'b00; req = 2'b01;
    wait_en("t7");
    req = 2'b00;
`ifdef MMC_SPI_TIMEOUT_EN
    push_exp(2'b01, 2'b01, exp_rd);
    n = 0;
    while (ack === 2'b00 && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("t7_tmo_latency", 32'(n), 32'd8);
    chk("t7_tmo_err", 32'(err), 32'h1);
    chk("t7_tmo_rd_data", 32'(rd_data), 32'(exp_rd));
    @(posedge sys_clk); #1;
    chk("t7_tmo_idle", 32'(arb_idle), 1);
`else
    repeat (1000) @(posedge sys_clk);
    #1;
    chk("t7_still_gnt", 32'(gnt), 32'h1);
    chk("t7_still_busy", 32'(arb_idle), 0);
    chk("t7_still_spi_en", 32'(spi_en), 1);
    chk("t7_no_err", 32'(err), 0);
    rst = 1'b1; @(posedge sys_clk); #1; rst = 1'b0;
`endif

    repeat (3) @(posedge sys_clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
